scalefac_pretab_encoder: RTL and testbench

//   Encoder-side counterpart of the requantizer's pretab addition: for a long-block

---
 rtl/scalefac_pretab_encoder.sv | 137 +++++++++++++
 tb/tb_scalefac_pretab_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/scalefac_pretab_encoder.sv
// Encoder-side pretab removal for long-block granules. Decides preflag and, when it
// is set, rewrites scalefactors of bands FIRST_SFB..LAST_SFB as (sf - pretab[sfb]).
module scalefac_pretab_encoder #(
  parameter int unsigned SF_WIDTH  = 4,
  parameter int unsigned FIRST_SFB = 11,
  parameter int unsigned LAST_SFB  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                long_block,
  output logic                busy,
  output logic                done,
  output logic                preflag,
  output logic                sf_rd_en,
  output logic [4:0]          sf_rd_addr,
  input  logic [SF_WIDTH-1:0] sf_rd_data,
  output logic                sf_wr_en,
  output logic [4:0]          sf_wr_addr,
  output logic [SF_WIDTH-1:0] sf_wr_data
);

  localparam int unsigned AW = 5;

  typedef enum logic [1:0] {IDLE, CHECK, ADJUST, FINISH} state_t;

  state_t                state, state_nxt;
  logic                  rd_en_nxt;
  logic [AW-1:0]         rd_addr_nxt;
  logic                  done_nxt;
  logic                  preflag_nxt;
  logic [1:0]            pretab_q;
  logic                  cmp_vld;
  logic [AW-1:0]         cmp_band;
  logic [SF_WIDTH-1:0]   pretab_ext_c;
  logic                  cmp_ok_c;
  logic                  last_cmp_c;
  logic                  more_rd_c;

  // 22-entry pretab table for long blocks
  function automatic logic [1:0] pretab_rom(input logic [AW-1:0] band);
    logic [1:0] val;
    val = 2'd0;
    case (band)
      5'd11, 5'd12, 5'd13, 5'd14: val = 2'd1;
      5'd15, 5'd16, 5'd20:        val = 2'd2;
      5'd17, 5'd18, 5'd19:        val = 2'd3;
      default:                    val = 2'd0;
    endcase
    return val;
  endfunction

  assign pretab_ext_c = SF_WIDTH'(pretab_q);
  assign cmp_ok_c     = (sf_rd_data >= pretab_ext_c);
  assign last_cmp_c   = (cmp_band == AW'(LAST_SFB));
  assign more_rd_c    = sf_rd_en && (sf_rd_addr != AW'(LAST_SFB));

  // Write-back uses RAM data the cycle it returns, so the write port is combinational
  assign sf_wr_en   = (state == ADJUST) && cmp_vld;
  assign sf_wr_addr = sf_wr_en ? cmp_band : '0;
  assign sf_wr_data = sf_wr_en ? (sf_rd_data - pretab_ext_c) : '0;

  always_comb begin
    state_nxt   = state;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = sf_rd_addr;
    done_nxt    = 1'b0;
    preflag_nxt = preflag;
    case (state)
      IDLE: begin
        if (start) begin
          preflag_nxt = 1'b0;
          if (long_block) begin
            state_nxt   = CHECK;
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = AW'(FIRST_SFB);
          end else begin
            state_nxt = FINISH;
            done_nxt  = 1'b1;
          end
        end
      end
      CHECK: begin
        if (cmp_vld && !cmp_ok_c) begin
          state_nxt   = FINISH;
          done_nxt    = 1'b1;
          preflag_nxt = 1'b0;
        end else if (cmp_vld && last_cmp_c) begin
          state_nxt   = ADJUST;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = AW'(FIRST_SFB);
        end else if (more_rd_c) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = sf_rd_addr + AW'(1);
        end
      end
      ADJUST: begin
        if (cmp_vld && last_cmp_c) begin
          state_nxt   = FINISH;
          done_nxt    = 1'b1;
          preflag_nxt = 1'b1;
        end else if (more_rd_c) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = sf_rd_addr + AW'(1);
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      preflag    <= 1'b0;
      sf_rd_en   <= 1'b0;
      sf_rd_addr <= '0;
      pretab_q   <= 2'd0;
      cmp_vld    <= 1'b0;
      cmp_band   <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      preflag    <= preflag_nxt;
      sf_rd_en   <= rd_en_nxt;
      sf_rd_addr <= rd_addr_nxt;
      // ROM output lines up with RAM data for the same band
      pretab_q   <= pretab_rom(sf_rd_addr);
      cmp_vld    <= sf_rd_en;
      cmp_band   <= sf_rd_addr;
    end
  end

endmodule

// File: tb/tb_scalefac_pretab_encoder.sv
// Bench for scalefac_pretab_encoder: RAM model plus a band-level reference model of
// preflag decision, completion latency, strobe counts and final scalefactor contents.
module tb_scalefac_pretab_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       long_block = 1'b0;
  logic       busy, done, preflag;
  logic       sf_rd_en, sf_wr_en;
  logic [4:0] sf_rd_addr, sf_wr_addr;
  logic [3:0] sf_rd_data;
  logic [3:0] sf_wr_data;

  always #5 clk = ~clk;

  scalefac_pretab_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .long_block(long_block),
    .busy(busy), .done(done), .preflag(preflag),
    .sf_rd_en(sf_rd_en), .sf_rd_addr(sf_rd_addr), .sf_rd_data(sf_rd_data),
    .sf_wr_en(sf_wr_en), .sf_wr_addr(sf_wr_addr), .sf_wr_data(sf_wr_data)
  );

  logic [3:0] mem [32];
  logic [3:0] img [32];
  logic [3:0] exp_mem [32];
  logic       load = 1'b0;
  int pt [22] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,2,2,3,3,3,2,0};
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, viol = 0;
  int errors = 0, checks = 0;

  // Simple dual-port scalefactor RAM with one-cycle read latency, plus strobe counters
  always @(posedge clk) begin
    if (load) mem <= img;
    else if (sf_wr_en) mem[sf_wr_addr] <= sf_wr_data;
    if (sf_rd_en) sf_rd_data <= mem[sf_rd_addr];
    if (sf_rd_en) rd_cnt <= rd_cnt + 1;
    if (sf_wr_en) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (sf_rd_en && sf_wr_en && sf_rd_addr == sf_wr_addr) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int b = 0; b < 32; b++) exp_mem[b] = img[b];
  endtask

  task automatic fill(input int lo, input int hi, input int v);
    for (int b = lo; b <= hi; b++) img[b] = 4'(v);
  endtask

  // Band-level model: preflag iff every band in 11..20 holds at least its pretab
  task automatic model(input bit lb, output int off, output int pf, output int erd,
                       output int ewr);
    int fi;
    fi = -1;
    for (int i = 0; i < 10; i++)
      if (fi < 0 && int'(exp_mem[11+i]) < pt[11+i]) fi = i;
    if (!lb) begin
      off = 1; pf = 0; erd = 0; ewr = 0;
    end else if (fi >= 0) begin
      off = 3 + fi; pf = 0; erd = (fi + 2 < 10) ? fi + 2 : 10; ewr = 0;
    end else begin
      off = 23; pf = 1; erd = 20; ewr = 10;
      for (int b = 11; b <= 20; b++) exp_mem[b] = 4'(int'(exp_mem[b]) - pt[b]);
    end
  endtask

  task automatic chk_mem();
    bit ok;
    ok = 1'b1;
    for (int b = 0; b < 32; b++) if (mem[b] !== exp_mem[b]) ok = 1'b0;
    chk("mem_contents", 32'(ok), 32'd1);
  endtask

  task automatic run_op(input bit lb, input bit pulse);
    int off, pf, erd, ewr, n, rd0, wr0, d0;
    bit got;
    model(lb, off, pf, erd, ewr);
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
    start = 1'b1; long_block = lb;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = pulse && (n == 4 || n == 14);
      long_block = 1'($urandom);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_cycle", 32'(n), 32'(off));
    chk("preflag_at_done", 32'(preflag), 32'(pf));
    chk("busy_in_finish", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("preflag_hold", 32'(preflag), 32'(pf));
    chk("rd_strobes", 32'(rd_cnt - rd0), 32'(erd));
    chk("wr_strobes", 32'(wr_cnt - wr0), 32'(ewr));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("same_addr_rw", 32'(viol), 32'd0);
    chk_mem();
  endtask

  task automatic run_abort();
    int wr0, n;
    fill(0, 31, 15);
    do_load();
    @(negedge clk);
    wr0 = wr_cnt;
    start = 1'b1; long_block = 1'b1;
    n = 0;
    while (n < 16) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero",
        32'({busy, done, preflag, sf_rd_en, sf_wr_en, sf_rd_addr, sf_wr_addr, sf_wr_data}),
        32'd0);
    repeat (3) @(negedge clk);
    chk("abort_held_zero", 32'({busy, done, sf_rd_en, sf_wr_en}), 32'd0);
    rst_n = 1'b1;
    for (int b = 11; b <= 13; b++) exp_mem[b] = 4'(int'(exp_mem[b]) - pt[b]);
    chk("abort_wr_strobes", 32'(wr_cnt - wr0), 32'd3);
    chk_mem();
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    chk("reset_outputs",
        32'({busy, done, preflag, sf_rd_en, sf_wr_en, sf_rd_addr, sf_wr_addr, sf_wr_data}),
        32'd0);
    @(negedge clk); rst_n = 1'b1;

    // all bands 15
    fill(0, 31, 15); do_load(); run_op(1'b1, 1'b0);
    // band 18 below its pretab of 3
    fill(0, 31, 3); img[18] = 4'd2; do_load(); run_op(1'b1, 1'b0);
    // short block
    fill(0, 31, 15); do_load(); run_op(1'b0, 1'b0);
    // start pulses while busy, then a back-to-back run
    fill(0, 31, 15); do_load(); run_op(1'b1, 1'b1); run_op(1'b1, 1'b0);
    // reset during ADJUST, then a clean rerun
    run_abort(); run_op(1'b1, 1'b0);
    // bands exactly equal to pretab
    fill(0, 31, 9);
    for (int b = 11; b <= 20; b++) img[b] = 4'(pt[b]);
    do_load(); run_op(1'b1, 1'b0);
    // randomized granules
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 32; b++) img[b] = 4'($urandom_range(0, 15));
      do_load();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)) && (k > 8) && 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
